// File: rtl/sipo_y_pp_pkg.sv
// Shared constants and helpers for the ping-pong y-sample SIPO buffer.
package sipo_y_pp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_PE_NUM     = 32;
    localparam int unsigned SIPO_DEPTH     = 128;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/sipo_y_pp_bank.sv
// One frame of complex-word storage: word-indexed write port and a
// combinational PE_NUM-word slice read port.
module sipo_bank
    import sipo_y_pp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PE_NUM     = DEF_PE_NUM,
    parameter int unsigned DEPTH      = SIPO_DEPTH,
    localparam int unsigned W         = 2 * DATA_WIDTH,
    localparam int unsigned NSLICE    = DEPTH / PE_NUM,
    localparam int unsigned AW        = clog2_min1(DEPTH),
    localparam int unsigned SW        = clog2_min1(NSLICE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         widx,
    input  logic [W-1:0]          wdata,
    input  logic [SW-1:0]         sidx,
    output logic [PE_NUM*W-1:0]   slice
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < PE_NUM; i++) begin
            slice[i*W +: W] = mem_q[AW'(32'(sidx) * PE_NUM + i)];
        end
    end

endmodule

// File: rtl/sipo_y_pp.sv
// Ping-pong serial-in parallel-out buffer: one bank fills from s_in while
// the other is read out as PE_NUM-word slices, with optional frame replay.
module sipo_y_pp
    import sipo_y_pp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PE_NUM     = DEF_PE_NUM,
    parameter int unsigned DEPTH      = SIPO_DEPTH,
    localparam int unsigned W         = 2 * DATA_WIDTH,
    localparam int unsigned NSLICE    = DEPTH / PE_NUM,
    localparam int unsigned AW        = clog2_min1(DEPTH),
    localparam int unsigned SW        = clog2_min1(NSLICE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_in_v,
    input  logic [W-1:0]          s_in,
    output logic                  s_in_rdy,
    input  logic                  shift_v,
    input  logic                  reuse,
    output logic                  p_out_v,
    output logic [PE_NUM*W-1:0]   p_out,
    output logic                  frame_rdy,
    output logic                  ovf
);

    if (DEPTH < PE_NUM || (DEPTH % PE_NUM) != 0) begin : g_bad_depth
        $error("sipo_y_pp: DEPTH must be a non-zero multiple of PE_NUM");
    end

    logic [1:0]          full_q, full_d;
    bank_e               wr_sel_q, wr_sel_d;
    bank_e               rd_sel_q, rd_sel_d;
    logic [AW-1:0]       wcnt_q, wcnt_d;
    logic [SW-1:0]       scnt_q, scnt_d;
    logic [PE_NUM*W-1:0] p_out_q, p_out_d;
    logic                p_out_v_q, p_out_v_d;
    logic                ovf_q, ovf_d;

    logic                wr_acc, rd_acc;
    logic [1:0]          bank_we;
    logic [PE_NUM*W-1:0] bank_slice [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sipo_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .PE_NUM     (PE_NUM),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .widx  (wcnt_q),
            .wdata (s_in),
            .sidx  (scnt_q),
            .slice (bank_slice[b])
        );
    end

    assign s_in_rdy  = !full_q[wr_sel_q];
    assign frame_rdy = full_q[rd_sel_q];
    assign p_out     = p_out_q;
    assign p_out_v   = p_out_v_q;
    assign ovf       = ovf_q;

    // Writes only target an empty bank and reads only a full one, so both
    // sides may update full_d in the same cycle without conflict.
    always_comb begin
        wr_acc    = s_in_v && s_in_rdy;
        rd_acc    = shift_v && frame_rdy;
        bank_we   = '0;
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wcnt_d    = wcnt_q;
        scnt_d    = scnt_q;
        p_out_d   = p_out_q;
        p_out_v_d = rd_acc;
        ovf_d     = ovf_q || (s_in_v && !s_in_rdy);

        if (wr_acc) begin
            bank_we[wr_sel_q] = 1'b1;
            if (wcnt_q == AW'(DEPTH - 1)) begin
                full_d[wr_sel_q] = 1'b1;
                wcnt_d           = '0;
                wr_sel_d         = other_bank(wr_sel_q);
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if (rd_acc) begin
            p_out_d = bank_slice[rd_sel_q];
            if (scnt_q == SW'(NSLICE - 1)) begin
                scnt_d = '0;
                if (!reuse) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = other_bank(rd_sel_q);
                end
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_sel_q  <= BANK_0;
            rd_sel_q  <= BANK_0;
            wcnt_q    <= '0;
            scnt_q    <= '0;
            p_out_q   <= '0;
            p_out_v_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wcnt_q    <= wcnt_d;
            scnt_q    <= scnt_d;
            p_out_q   <= p_out_d;
            p_out_v_q <= p_out_v_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
